// File: rtl/sha_uart_pkg.sv
// ============================================================================
// Module : sha_uart_pkg
// Brief  : Shared types, ASCII constants and helpers for sha_digest_uart_tx
// Rev    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package sha_uart_pkg;

  // Serializer and sequencer states. Explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h57 + {4'h0, nibble};  // 0x57 + 10 = 'a'
  endfunction

  // Total number of UART frames emitted for one digest.
  function automatic int n_bytes(input int digest_w, input int hex_mode, input int append_crlf);
    int n;
    n = (hex_mode != 0) ? (digest_w / 4) : (digest_w / 8);
    if (append_crlf != 0) begin
      n = n + 2;
    end
    return n;
  endfunction

endpackage : sha_uart_pkg

`default_nettype wire

// File: rtl/uart_byte_serializer.sv
// ============================================================================
// Module : uart_byte_serializer
// Brief  : 8N1/8N2 UART frame generator. Owns baud, bit and stop-bit timing.
//          i_byte must stay stable for the whole frame; a new frame may be
//          chained on the last stop-bit cycle for gap-free streaming.
// Rev    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module uart_byte_serializer
  import sha_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_byte_serializer: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_byte_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit;
  logic                r_stop;
  logic                r_tx;

  logic                w_bit_end;
  logic                w_last_stop;
  logic [2:0]          w_bit_nxt;

  assign w_bit_end    = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_stop  = (r_stop == 1'(STOP_BITS - 1));
  assign w_bit_nxt    = r_bit + 3'd1;
  assign o_frame_done = (r_state == ST_STOP) && w_bit_end && w_last_stop;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_tx         = r_tx;

  // Frame timing: line level is registered so it changes exactly on bit edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_START;
            r_baud  <= '0;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= i_byte[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_stop  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= w_bit_nxt;
              r_tx  <= i_byte[w_bit_nxt];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_last_stop) begin
              // Chain straight into the next start bit when more data follows.
              if (i_start) begin
                r_state <= ST_START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule : uart_byte_serializer

`default_nettype wire

// File: rtl/sha_digest_uart_tx.sv
// ============================================================================
// Module : sha_digest_uart_tx
// Brief  : Streams a digest over UART, raw or as lowercase ASCII hex, with an
//          optional CR/LF trailer and a valid/ready capture handshake.
// Rev    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sha_digest_uart_tx
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_W     = 256,
  parameter int CLKS_PER_BIT = 87,
  parameter int STOP_BITS    = 1,
  parameter int HEX_MODE     = 1,
  parameter int APPEND_CRLF  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_uart_tx,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N_BYTES = n_bytes(DIGEST_W, HEX_MODE, APPEND_CRLF);
  localparam int N_CHARS = (HEX_MODE != 0) ? (DIGEST_W / 4) : (DIGEST_W / 8);
  localparam int CNT_W   = $clog2(N_BYTES + 1);
  localparam int SHIFT_W = (HEX_MODE != 0) ? 4 : 8;

  generate
    if ((DIGEST_W % 8) != 0 || DIGEST_W < 8) begin : g_bad_digest_w
      $error("sha_digest_uart_tx: DIGEST_W must be a non-zero multiple of 8");
    end
  endgenerate

  // Top-level sequencer only uses IDLE, START (frames in flight) and DONE;
  // bit-level START/DATA/STOP timing lives in the serializer.
  state_t              r_state;
  logic [DIGEST_W-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_last;
  logic                w_frame_done;
  logic                w_ser_start;
  logic                w_ser_busy;
  logic [7:0]          w_byte;

  assign o_ready     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign o_busy      = (r_state == ST_START);
  assign o_done      = (r_state == ST_DONE);
  assign w_accept    = i_valid && o_ready;
  assign w_last      = (r_cnt == CNT_W'(N_BYTES - 1));
  // Start byte 0 on the handshake edge itself so the start bit appears next cycle.
  assign w_ser_start = w_accept || ((r_state == ST_START) && w_frame_done && !w_last);

  // Byte source: encoded top of the shift register, then the CR/LF trailer.
  always_comb begin
    w_byte = 8'hFF;
    if (r_cnt < CNT_W'(N_CHARS)) begin
      if (HEX_MODE != 0) begin
        w_byte = hex_ascii(r_shift[DIGEST_W-1 -: 4]);
      end else begin
        w_byte = r_shift[DIGEST_W-1 -: 8];
      end
    end else if (r_cnt == CNT_W'(N_CHARS)) begin
      w_byte = ASCII_CR;
    end else begin
      w_byte = ASCII_LF;
    end
  end

  // Handshake capture, per-frame shift/count and the one-cycle DONE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= ST_START;
      r_shift <= i_digest;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_START: begin
          if (w_frame_done) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_shift <= r_shift << SHIFT_W;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_ser (
    .clk          (clk),
    .rst          (rst),
    .i_byte       (w_byte),
    .i_start      (w_ser_start),
    .o_busy       (w_ser_busy),
    .o_frame_done (w_frame_done),
    .o_tx         (o_uart_tx)
  );

  // Serializer busy is implied by the sequencer state; kept for debug probing.
  logic w_unused;
  assign w_unused = w_ser_busy;

endmodule : sha_digest_uart_tx

`default_nettype wire

// File: tb/tb_sha_digest_uart_tx.sv
// ============================================================================
// Module : tb_sha_digest_uart_tx
// Brief  : Scoreboard bench: stimulus pushes expected bytes, a UART monitor
//          decodes the active DUT's line and pops/compares each byte.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sha_digest_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: C=4, 16-bit raw, 1 stop, no CR/LF
  logic [15:0]  a_dig;
  logic         a_valid, a_ready, a_tx, a_busy, a_done;
  // DUT B: all defaults
  logic [255:0] b_dig;
  logic         b_valid, b_ready, b_tx, b_busy, b_done;
  // DUT C: C=4, 8-bit raw, 2 stop bits, no CR/LF
  logic [7:0]   c_dig;
  logic         c_valid, c_ready, c_tx, c_busy, c_done;

  sha_digest_uart_tx #(.DIGEST_W(16), .CLKS_PER_BIT(4), .STOP_BITS(1), .HEX_MODE(0), .APPEND_CRLF(0)) u_a (
    .clk(clk), .rst(rst), .i_digest(a_dig), .i_valid(a_valid), .o_ready(a_ready),
    .o_uart_tx(a_tx), .o_busy(a_busy), .o_done(a_done));

  sha_digest_uart_tx u_b (
    .clk(clk), .rst(rst), .i_digest(b_dig), .i_valid(b_valid), .o_ready(b_ready),
    .o_uart_tx(b_tx), .o_busy(b_busy), .o_done(b_done));

  sha_digest_uart_tx #(.DIGEST_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .HEX_MODE(0), .APPEND_CRLF(0)) u_c (
    .clk(clk), .rst(rst), .i_digest(c_dig), .i_valid(c_valid), .o_ready(c_ready),
    .o_uart_tx(c_tx), .o_busy(c_busy), .o_done(c_done));

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;
  int mon_c    = 4;
  int r_low, r_first_high;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  function automatic logic get_tx(input int d);
    return (d == 0) ? a_tx : (d == 1) ? b_tx : c_tx;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? a_done : (d == 1) ? b_done : c_done;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? a_busy : (d == 1) ? b_busy : c_busy;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? a_ready : (d == 1) ? b_ready : c_ready;
  endfunction

  task automatic set_in(input int d, input logic [255:0] dig, input logic v);
    case (d)
      0:       begin a_dig = dig[15:0]; a_valid = v; end
      1:       begin b_dig = dig;       b_valid = v; end
      default: begin c_dig = dig[7:0];  c_valid = v; end
    endcase
  endtask

  // UART monitor on the selected DUT: samples mid-bit, checks stop, pops scoreboard.
  initial begin
    int         m_cnt;
    bit         m_in;
    logic [7:0] m_sh;
    logic [7:0] e;
    m_cnt = 0; m_in = 0; m_sh = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        m_in = 0;
      end else if (!m_in) begin
        if (get_tx(sel) == 1'b0) begin
          m_in = 1; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 9 * mon_c + mon_c / 2) begin
          chk("stop_bit", 32'(get_tx(sel)), 32'd1);
          m_in = 0;
          rx_log.push_back(m_sh);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: actual %02h required none", m_sh);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", 32'(m_sh), 32'(e));
          end
        end else if (m_cnt >= mon_c + mon_c / 2 && ((m_cnt - mon_c / 2) % mon_c) == 0) begin
          m_sh = {get_tx(sel), m_sh[7:1]};
        end
      end
    end
  end

  // One transfer: handshake, optional held valid, bounded wait for o_done.
  task automatic run_xfer(input int d, input logic [255:0] dig, input logic [255:0] nxt,
                          input bit hold, input int exp_done, input string nm);
    int idx;
    int lim;
    set_in(d, dig, 1'b1);
    @(posedge clk); #1;
    set_in(d, nxt, hold);
    chk({nm, "_busy"},  32'(get_busy(d)),  32'd1);
    chk({nm, "_ready"}, 32'(get_ready(d)), 32'd0);
    chk({nm, "_start"}, 32'(get_tx(d)),    32'd0);
    idx = 1; lim = exp_done + 20; r_low = 0; r_first_high = 0;
    while (idx < lim && get_done(d) !== 1'b1) begin
      if (get_tx(d) == 1'b0) r_low++;
      else if (r_first_high == 0) r_first_high = idx;
      @(posedge clk); #1;
      idx++;
    end
    chk({nm, "_done_cycle"}, 32'(idx), 32'(exp_done));
  endtask

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    logic [7:0] digits [16];
    digits = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    return digits[n];
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] abc;
    int           bad_tx, bad_busy, n_done;
    abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    rst = 1'b0;
    set_in(0, '0, 1'b0); set_in(1, '0, 1'b0); set_in(2, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tx", 32'(a_tx), 32'd1);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_b_tx", 32'(b_tx), 32'd1);
    chk("rst_c_ready", 32'(c_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Test 1: raw 16-bit A55A, done 2*40+1 cycles after handshake; later i_digest change ignored
    sel = 0; mon_c = 4;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    run_xfer(0, 256'hA55A, 256'hFFFF, 1'b0, 81, "t1");
    @(posedge clk); #1;
    chk("t1_done_pulse_width", 32'(a_done), 32'd0);
    chk("t1_ready_after", 32'(a_ready), 32'd1);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 3: 2 stop bits, 8'h00: 36 low, 8 high, done at 45
    sel = 2; mon_c = 4;
    exp_q.push_back(8'h00);
    run_xfer(2, 256'h00, 256'hFF, 1'b0, 45, "t3");
    chk("t3_low_cycles", 32'(r_low), 32'd36);
    chk("t3_first_high", 32'(r_first_high), 32'd37);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 4: valid held with second digest; accepted only in DONE cycle
    sel = 0; mon_c = 4;
    @(posedge clk); #1;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    run_xfer(0, 256'h1234, 256'hBEEF, 1'b1, 81, "t4a");
    chk("t4_ready_in_done", 32'(a_ready), 32'd1);
    run_xfer(0, 256'hBEEF, 256'h0, 1'b0, 81, "t4b");
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 5: reset during DATA, then a fresh transfer
    @(posedge clk); #1;
    set_in(0, 256'hC3C3, 1'b1);
    @(posedge clk); #1;
    set_in(0, 256'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("t5_busy_pre", 32'(a_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(a_tx), 32'd1);
    chk("t5_rst_ready", 32'(a_ready), 32'd1);
    chk("t5_rst_busy", 32'(a_busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (a_done) n_done++;
    end
    chk("t5_no_done", 32'(n_done), 32'd0);
    rst = 1'b1;
    exp_q.push_back(8'h0F); exp_q.push_back(8'h96);
    run_xfer(0, 256'h0F96, 256'h0, 1'b0, 81, "t5");
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 6: 1000 idle cycles
    bad_tx = 0; bad_busy = 0; n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (a_tx !== 1'b1) bad_tx++;
      if (a_busy !== 1'b0) bad_busy++;
      if (a_done !== 1'b0) n_done++;
    end
    chk("t6_tx_idle", 32'(bad_tx), 32'd0);
    chk("t6_busy_idle", 32'(bad_busy), 32'd0);
    chk("t6_no_done", 32'(n_done), 32'd0);

    // Test 2: defaults, SHA-256("abc") as 64 hex chars + CR LF, done at 66*870+1
    sel = 1; mon_c = 87;
    rx_log.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(to_hex(abc[255 - 4 * i -: 4]));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    run_xfer(1, abc, ~abc, 1'b0, 66 * 870 + 1, "t2");
    chk("t2_char_count", 32'(rx_log.size()), 32'd66);
    if (rx_log.size() >= 66) begin
      chk("t2_char0", 32'(rx_log[0]), 32'h62);
      chk("t2_char1", 32'(rx_log[1]), 32'h61);
      chk("t2_char63", 32'(rx_log[63]), 32'h64);
      chk("t2_cr", 32'(rx_log[64]), 32'h0D);
      chk("t2_lf", 32'(rx_log[65]), 32'h0A);
    end
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sha_digest_uart_tx

`default_nettype wire
